sl_tx_queued: RTL and testbench
===============================

SL_TX_QUEUED -- requirements
Module: sl_tx_queued

Interface
REQ-001 SHALL have parameter DATA_W, default 32, maximum word length in bits (even, 8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of queued words (power of 2, >=2).
REQ-003 SHALL have parameter GAP_PHASES, default 4, number of idle phases inserted between words.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_a  in  DATA_W  word to queue.
REQ-007 SHALL have port send_imm  in  1  push strobe; data_a is written to the FIFO when high.
REQ-008 SHALL have port fifo_full  out  1  FIFO holds FIFO_DEPTH words.
REQ-009 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued words.
REQ-010 SHALL have port wr_config_w  in  10  config word: [5:0] length, [6] parity mode (0 odd, 1 even), [9:7] freq mode.
REQ-011 SHALL have port wr_config_enable  in  1  config write strobe.
REQ-012 SHALL have port r_config_w  out  10  currently active config word.
REQ-013 SHALL have port cfg_err  out  1  one-cycle pulse when a config write is rejected.
REQ-014 SHALL have port overflow  out  1  sticky flag: a push was dropped.
REQ-015 SHALL have port send_in_process  out  1  word on the line.
REQ-016 SHALL have port status_changed  out  1  one-cycle pulse on every send_in_process edge.
REQ-017 SHALL have ports SL0, SL1  out  1 each  serial line pair; idle high.

Function
REQ-018 SHALL compute the phase length P = 2^freq_mode clocks; freq_mode range is 0..5.
REQ-019 SHALL reject a config write whose length is odd, <8, or >DATA_W, or whose freq_mode is >5: config stays unchanged and cfg_err pulses on the next cycle.
REQ-020 SHALL make an accepted config write visible on r_config_w the next cycle, apply it only at the next word start, and clear overflow.
REQ-021 SHALL use an FSM with states IDLE, BIT_LOW, BIT_HIGH, PAR_LOW, PAR_HIGH, STOP, GAP.
REQ-022 SHALL, in IDLE with fifo_level>0, pop the head word, latch the active config, and enter BIT_LOW on the next cycle.
REQ-023 SHALL transmit bits [len-1:0], LSB first; each bit is P clocks in BIT_LOW followed by P clocks in BIT_HIGH.
REQ-024 SHALL, during BIT_LOW, drive SL1 low for a '1' bit or SL0 low for a '0' bit while the other line stays high.
REQ-025 SHALL drive both lines high during BIT_HIGH.
REQ-026 SHALL, after the last data bit, send a parity bit (PAR_LOW/PAR_HIGH) with the same encoding; for odd mode the total count of ones including parity is odd, and for even mode it is even.
REQ-027 SHALL, in STOP, drive both lines low for P clocks and then enter GAP.
REQ-028 SHALL hold both lines high in GAP for GAP_PHASES*P clocks, then enter IDLE.
REQ-029 SHALL assert send_in_process from the first BIT_LOW cycle through the last STOP cycle, i.e. (2*len+3)*P clocks.
REQ-030 SHALL give a latency of 2 cycles from a push (FIFO empty, FSM in IDLE) at cycle N to the first line low at cycle N+2.
REQ-031 SHALL start back-to-back queued words exactly GAP_PHASES*P+1 clocks after the previous STOP ends, with no other idle time.
REQ-032 SHALL register all outputs; SL0/SL1 SHALL be glitch-free flop outputs.
REQ-033 SHALL, on a push while full, drop data_a, leave the FIFO unchanged, and set overflow.
REQ-034 SHALL, on simultaneous push and pop while full, accept the push because the pop frees a slot.
REQ-035 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-036 SHALL ignore data bits above len-1.

Reset
REQ-037 SHALL, on rst_n low, immediately force SL0=SL1=1, send_in_process=0, status_changed=0, cfg_err=0, overflow=0, fifo_level=0, fifo_full=0, FSM=IDLE, and config = {3'd0, 1'b0, DATA_W[5:0]}.
REQ-038 SHALL, on reset during a word, abort the word, flush the FIFO, and emit no stop phase.
REQ-039 SHALL begin operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-040 SHALL be verified for: config 0x008 (len 8, odd, P=1), push 0xA5 -> SL1,SL0 lows in pattern 1,0,1,0,0,1,0,1 LSB first, then parity '1' on SL1, then stop both low 1 clk; send_in_process high 19 clk.
REQ-041 SHALL be verified for: config {3'd2, 1'b1, 6'd16} (P=4, even), push 0x0003 -> parity '0' on SL0, send_in_process high 140 clk, status_changed pulses exactly twice.
REQ-042 SHALL be verified for: FIFO_DEPTH=4, 6 pushes in consecutive cycles while busy -> fifo_full=1 after 4 queued, overflow=1, exactly 5 words transmitted, each separated by GAP_PHASES*P+1 idle clocks.
REQ-043 SHALL be verified for: config write length 9, then freq_mode 6 -> cfg_err pulses twice and r_config_w is unchanged; config write during a word changes r_config_w next cycle, while the current word keeps its old length.
REQ-044 SHALL be verified for: rst_n low mid-data-bit -> SL0=SL1=1 with no clock edge, fifo_level=0, and no further transmission after release until a new push.
REQ-045 SHALL be verified for: random len in {8..32 even}, mode 0..5, and random data checked against an ideal receiver for data, bit count, and parity.

Source files
------------

// File: rtl/sl_tx_queued.sv
// Queued two-wire serial transmitter. Words wait in a small FIFO and are sent LSB first
// as low/high phase pairs on SL0/SL1, then a parity bit, a stop phase and an idle gap.
module sl_tx_queued #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_PHASES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           data_a,
  input  logic                        send_imm,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic [9:0]                  wr_config_w,
  input  logic                        wr_config_enable,
  output logic [9:0]                  r_config_w,
  output logic                        cfg_err,
  output logic                        overflow,
  output logic                        send_in_process,
  output logic                        status_changed,
  output logic                        SL0,
  output logic                        SL1
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = $clog2(GAP_PHASES * 32) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GAP_PHASES);
  localparam logic [LW-1:0]    LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [6:0]       LEN_MAX   = 7'(DATA_W);
  localparam logic [9:0]       CFG_RESET = {3'd0, 1'b0, 6'(DATA_W)};

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BIT_LOW  = 3'd1;
  localparam logic [2:0] S_BIT_HIGH = 3'd2;
  localparam logic [2:0] S_PAR_LOW  = 3'd3;
  localparam logic [2:0] S_PAR_HIGH = 3'd4;
  localparam logic [2:0] S_STOP     = 3'd5;
  localparam logic [2:0] S_GAP      = 3'd6;

  // Parity over the low len bits: even mode makes the total ones count even.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic [5:0] len,
                                      input logic even_mode);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      acc = acc ^ (d[i] & (i < int'(len)));
    end
    return even_mode ? acc : ~acc;
  endfunction

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]     level_r, level_nx_s;
  logic              full_r, pop_s, push_ok_s, drop_s;

  logic [9:0] cfg_r;
  logic       cfg_ok_s, cfg_err_r, overflow_r;

  logic [2:0]        state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s, p_cfg_m1_s, p_m1_s, gap_m1_s;
  logic [5:0]        bit_r, bit_nx_s, len_r, len_nx_s;
  logic [2:0]        freq_r, freq_nx_s;
  logic [DATA_W-1:0] shift_r, shift_nx_s;
  logic              par_r, par_nx_s;
  logic              sl0_r, sl1_r, sip_r, sc_r, sl0_nx_s, sl1_nx_s, sip_nx_s;

  assign pop_s     = (state_r == S_IDLE) && (level_r != LW'(0));
  assign push_ok_s = send_imm && (!full_r || pop_s);
  assign drop_s    = send_imm && !push_ok_s;

  assign cfg_ok_s = !wr_config_w[0] && (wr_config_w[5:0] >= 6'd8) &&
                    ({1'b0, wr_config_w[5:0]} <= LEN_MAX) && (wr_config_w[9:7] <= 3'd5);

  assign p_cfg_m1_s = (CNT_ONE << cfg_r[9:7]) - CNT_ONE;
  assign p_m1_s     = (CNT_ONE << freq_r) - CNT_ONE;
  assign gap_m1_s   = (CNT_GAP << freq_r) - CNT_ONE;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    level_nx_s = level_r;
    case ({push_ok_s, pop_s})
      2'b10:   level_nx_s = level_r + LW'(1);
      2'b01:   level_nx_s = level_r - LW'(1);
      default: level_nx_s = level_r;
    endcase
  end

  // FIFO pointers and level; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_nx_s;
      full_r  <= (level_nx_s == LVL_FULL);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= data_a;
  end

  // Config register, reject pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_r      <= CFG_RESET;
      cfg_err_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      cfg_err_r <= wr_config_enable && !cfg_ok_s;
      if (wr_config_enable && cfg_ok_s) cfg_r <= wr_config_w;
      if (drop_s)                                overflow_r <= 1'b1;
      else if (wr_config_enable && cfg_ok_s)     overflow_r <= 1'b0;
    end
  end

  // Transmit sequencer next state; the config is latched only when a word is popped.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    bit_nx_s   = bit_r;
    len_nx_s   = len_r;
    freq_nx_s  = freq_r;
    shift_nx_s = shift_r;
    par_nx_s   = par_r;
    case (state_r)
      S_IDLE: begin
        if (pop_s) begin
          state_nx_s = S_BIT_LOW;
          cnt_nx_s   = p_cfg_m1_s;
          bit_nx_s   = 6'd0;
          len_nx_s   = cfg_r[5:0];
          freq_nx_s  = cfg_r[9:7];
          shift_nx_s = mem_r[rd_ptr_r];
          par_nx_s   = parity_bit(mem_r[rd_ptr_r], cfg_r[5:0], cfg_r[6]);
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_BIT_LOW: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_BIT_HIGH;
          cnt_nx_s   = p_m1_s;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_BIT_HIGH: begin
        if (cnt_r == CNT_ZERO) begin
          cnt_nx_s = p_m1_s;
          if (bit_r == len_r - 6'd1) begin
            state_nx_s = S_PAR_LOW;
          end else begin
            state_nx_s = S_BIT_LOW;
            bit_nx_s   = bit_r + 6'd1;
            shift_nx_s = shift_r >> 1;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_PAR_LOW: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_PAR_HIGH;
          cnt_nx_s   = p_m1_s;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_PAR_HIGH: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_STOP;
          cnt_nx_s   = p_m1_s;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_GAP;
          cnt_nx_s   = gap_m1_s;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_IDLE;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Line levels decoded from the next state so the flops switch together with the FSM.
  always_comb begin
    sl0_nx_s = 1'b1;
    sl1_nx_s = 1'b1;
    case (state_nx_s)
      S_BIT_LOW: begin
        sl0_nx_s = shift_nx_s[0];
        sl1_nx_s = ~shift_nx_s[0];
      end
      S_PAR_LOW: begin
        sl0_nx_s = par_nx_s;
        sl1_nx_s = ~par_nx_s;
      end
      S_STOP: begin
        sl0_nx_s = 1'b0;
        sl1_nx_s = 1'b0;
      end
      default: begin
        sl0_nx_s = 1'b1;
        sl1_nx_s = 1'b1;
      end
    endcase
  end

  assign sip_nx_s = (state_nx_s != S_IDLE) && (state_nx_s != S_GAP);

  // Sequencer state and registered line/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 6'd0;
      len_r   <= 6'(DATA_W);
      freq_r  <= 3'd0;
      shift_r <= {DATA_W{1'b0}};
      par_r   <= 1'b0;
      sl0_r   <= 1'b1;
      sl1_r   <= 1'b1;
      sip_r   <= 1'b0;
      sc_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      bit_r   <= bit_nx_s;
      len_r   <= len_nx_s;
      freq_r  <= freq_nx_s;
      shift_r <= shift_nx_s;
      par_r   <= par_nx_s;
      sl0_r   <= sl0_nx_s;
      sl1_r   <= sl1_nx_s;
      sip_r   <= sip_nx_s;
      sc_r    <= sip_nx_s ^ sip_r;
    end
  end

  assign fifo_full       = full_r;
  assign fifo_level      = level_r;
  assign r_config_w      = cfg_r;
  assign cfg_err         = cfg_err_r;
  assign overflow        = overflow_r;
  assign send_in_process = sip_r;
  assign status_changed  = sc_r;
  assign SL0             = sl0_r;
  assign SL1             = sl1_r;

endmodule

// File: tb/tb_sl_tx_queued.sv
// Bench for sl_tx_queued: an ideal line receiver decodes every frame and compares it
// with the words the bench queued, plus directed checks of FIFO, config and reset.
module tb_sl_tx_queued;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_PHASES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_a;
  logic        send_imm;
  logic        fifo_full;
  logic [2:0]  fifo_level;
  logic [9:0]  wr_config_w;
  logic        wr_config_enable;
  logic [9:0]  r_config_w;
  logic        cfg_err, overflow, send_in_process, status_changed, SL0, SL1;

  sl_tx_queued #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .GAP_PHASES(GAP_PHASES)) dut (
    .clk(clk), .rst_n(rst_n), .data_a(data_a), .send_imm(send_imm),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .wr_config_w(wr_config_w),
    .wr_config_enable(wr_config_enable), .r_config_w(r_config_w), .cfg_err(cfg_err),
    .overflow(overflow), .send_in_process(send_in_process), .status_changed(status_changed),
    .SL0(SL0), .SL1(SL1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          len;
    bit          even;
    int          freq;
  } exp_t;

  exp_t       exp_q[$];
  int         starts_q[$];
  int         ends_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         sc_cnt = 0;
  int         last_push_cyc = 0;
  bit         last_par = 1'b0;
  logic [9:0] cfg_m;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Ideal receiver: decodes symbols from line levels sampled on the falling edge.
  initial begin
    logic [1:0]  prev, cur, sym;
    logic [63:0] rx, mask;
    int          low_len, sip_cnt, p, ones;
    bit          in_frame;
    bit          bits[$];
    exp_t        e;
    prev = 2'b11; sym = 2'b11; low_len = 0; sip_cnt = 0; in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 2'b11; in_frame = 1'b0; bits.delete(); low_len = 0; sip_cnt = 0;
      end else begin
        cur = {SL1, SL0};
        p = (exp_q.size() > 0) ? (1 << exp_q[0].freq) : 1;
        if (status_changed) sc_cnt++;
        if (cur != 2'b11) begin
          if (prev == 2'b11) begin
            if (!in_frame) begin
              in_frame = 1'b1;
              bits.delete();
              sip_cnt = 0;
              starts_q.push_back(cyc);
              check_eq("frame_expected", exp_q.size() > 0, 1'b1);
            end
            sym = cur;
            low_len = 1;
          end else if (cur == prev) begin
            low_len++;
          end else begin
            check_eq("line_change_while_low", cur, prev);
          end
        end else if (prev != 2'b11) begin
          check_eq("low_phase_len", low_len, p);
          if (sym == 2'b00) begin
            in_frame = 1'b0;
            ends_q.push_back(cyc);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check_eq("bit_count", bits.size(), e.len + 1);
              rx = 64'd0; ones = 0;
              mask = (64'd1 << e.len) - 64'd1;
              foreach (bits[i]) begin
                if (i < e.len) rx[i] = bits[i];
                ones += int'(bits[i]);
              end
              check_eq("rx_data", rx, {32'd0, e.data} & mask);
              check_eq("parity", ones % 2, e.even ? 0 : 1);
              check_eq("sip_len", sip_cnt, (2 * e.len + 3) * (1 << e.freq));
              if (bits.size() > 0) last_par = bits[$];
            end
          end else begin
            bits.push_back(sym == 2'b01);
          end
        end
        if (send_in_process) sip_cnt++;
        prev = cur;
      end
    end
  end

  task automatic write_cfg(input logic [9:0] w);
    int len;
    bit ok;
    len = int'(w[5:0]);
    ok = (len % 2 == 0) && (len >= 8) && (len <= DATA_W) && (int'(w[9:7]) <= 5);
    if (ok) cfg_m = w;
    wr_config_w = w;
    wr_config_enable = 1'b1;
    tick;
    wr_config_enable = 1'b0;
    @(negedge clk);
    check_eq("cfg_err", cfg_err, !ok);
    check_eq("r_config_w", r_config_w, cfg_m);
    if (ok) check_eq("overflow_cleared", overflow, 1'b0);
    @(negedge clk);
    check_eq("cfg_err_one_cycle", cfg_err, 1'b0);
    tick;
  endtask

  task automatic push(input logic [31:0] d, input bit accept);
    exp_t e;
    send_imm = 1'b1;
    data_a = d;
    last_push_cyc = cyc;
    if (accept) begin
      e.data = d; e.len = int'(cfg_m[5:0]); e.even = cfg_m[6]; e.freq = int'(cfg_m[9:7]);
      exp_q.push_back(e);
    end
    tick;
    send_imm = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || send_in_process === 1'b1) && n < limit) begin
      tick;
      n++;
    end
    check_eq("done_in_time", n < limit, 1'b1);
    repeat (GAP_PHASES * 32 + 4) tick;
  endtask

  task automatic wait_busy;
    int n;
    n = 0;
    while (send_in_process !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    check_eq("busy_in_time", n < 100, 1'b1);
  endtask

  initial begin
    logic [9:0] bad_cfg [5];
    int         nfr, len, freq;
    bit         ev;
    data_a = 32'd0; send_imm = 1'b0; wr_config_w = 10'd0; wr_config_enable = 1'b0;
    cfg_m = 10'h020;
    bad_cfg[0] = 10'h009; bad_cfg[1] = 10'h308; bad_cfg[2] = 10'h006;
    bad_cfg[3] = 10'h022; bad_cfg[4] = 10'h388;

    #12;
    check_eq("rst_SL0", SL0, 1'b1);
    check_eq("rst_SL1", SL1, 1'b1);
    check_eq("rst_sip", send_in_process, 1'b0);
    check_eq("rst_sc", status_changed, 1'b0);
    check_eq("rst_cfg_err", cfg_err, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_level", fifo_level, 3'd0);
    check_eq("rst_full", fifo_full, 1'b0);
    check_eq("rst_config", r_config_w, 10'h020);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // 0xA5, len 8, odd parity, P=1
    write_cfg(10'h008);
    starts_q.delete(); ends_q.delete();
    push(32'h0000_00A5, 1'b1);
    wait_done(2000);
    check_eq("a5_frames", starts_q.size(), 1);
    if (starts_q.size() > 0) check_eq("push_latency", starts_q[0] - last_push_cyc, 2);
    check_eq("a5_parity_bit", last_par, 1'b1);

    // 0x0003, len 16, even parity, P=4
    write_cfg({3'd2, 1'b1, 6'd16});
    sc_cnt = 0;
    push(32'h0000_0003, 1'b1);
    wait_done(4000);
    check_eq("status_changed_pulses", sc_cnt, 2);
    check_eq("0003_parity_bit", last_par, 1'b0);

    // six consecutive pushes from idle: five words go out, the sixth is dropped
    write_cfg(10'h008);
    starts_q.delete(); ends_q.delete();
    for (int i = 0; i < 6; i++) push(32'h0000_0010 + 32'(i), i < 5);
    @(negedge clk);
    check_eq("burst_full", fifo_full, 1'b1);
    check_eq("burst_level", fifo_level, 3'd4);
    check_eq("burst_overflow", overflow, 1'b1);
    wait_done(5000);
    check_eq("burst_frames", starts_q.size(), 5);
    for (int k = 0; k + 1 < starts_q.size() && k < ends_q.size(); k++)
      check_eq("burst_gap", starts_q[k + 1] - ends_q[k], GAP_PHASES + 1);
    check_eq("overflow_sticky", overflow, 1'b1);
    write_cfg(10'h008);

    // rejected config writes
    foreach (bad_cfg[i]) write_cfg(bad_cfg[i]);

    // config change mid-word: visible at once, current word keeps length 8
    push(32'hFFFF_F05A, 1'b1);
    wait_busy;
    write_cfg(10'h010);
    wait_done(4000);

    // reset in the middle of a data bit with a second word queued
    write_cfg(10'h110);
    push(32'h0000_BEEF, 1'b1);
    push(32'h0000_1234, 1'b1);
    wait_busy;
    repeat (10) tick;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_SL0", SL0, 1'b1);
    check_eq("async_rst_SL1", SL1, 1'b1);
    check_eq("async_rst_level", fifo_level, 3'd0);
    check_eq("async_rst_sip", send_in_process, 1'b0);
    exp_q.delete();
    cfg_m = 10'h020;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    check_eq("post_rst_config", r_config_w, 10'h020);
    nfr = starts_q.size();
    repeat (300) tick;
    check_eq("no_tx_after_rst", starts_q.size(), nfr);
    check_eq("post_rst_level", fifo_level, 3'd0);
    push(32'hC3C3_5A5A, 1'b1);
    wait_done(3000);
    check_eq("tx_after_rst", starts_q.size(), nfr + 1);

    // random lengths, modes and data
    for (int it = 0; it < 12; it++) begin
      len  = 8 + 2 * int'($urandom_range(0, 12));
      freq = int'($urandom_range(0, 5));
      ev   = 1'($urandom_range(0, 1));
      write_cfg({3'(freq), ev, 6'(len)});
      push($urandom, 1'b1);
      wait_done(6000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
